// File: rtl/reg_trace_tx.sv
// Register-file trace transmitter: captures the 56-bit {A,B,C,D,E,H,L} view on
// request and streams a 10-byte frame (header, seq, 7 regs, xor checksum) over valid/ready.
module reg_trace_tx #(
  parameter logic [7:0] HEADER = 8'hA5,
  parameter int         DROP_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              snap_req,
  input  logic [55:0]       regs_in,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic [7:0]        seq,
  output logic [DROP_W-1:0] drop_cnt
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR  = 3'd1,
    S_SEQ  = 3'd2,
    S_REG  = 3'd3,
    S_CSUM = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_state_nx;
  logic [2:0]          r_idx;
  logic [2:0]          w_idx_nx;
  logic [55:0]         r_snap;
  logic [55:0]         w_snap_nx;
  logic [7:0]          r_csum;
  logic [7:0]          w_csum_nx;
  logic [7:0]          r_seq;
  logic [7:0]          w_seq_nx;
  logic [7:0]          r_tx_data;
  logic [7:0]          w_data_nx;
  logic                r_tx_valid;
  logic                w_valid_nx;
  logic [DROP_W-1:0]   r_drop;
  logic [DROP_W-1:0]   w_drop_nx;
  logic                w_xfer;

  // Byte idx of the snapshot, A (idx 0) in the top byte down to L (idx 6).
  function automatic logic [7:0] sel_byte(input logic [55:0] snap, input logic [2:0] idx);
    logic [7:0] b;
    case (idx)
      3'd0:    b = snap[55:48];
      3'd1:    b = snap[47:40];
      3'd2:    b = snap[39:32];
      3'd3:    b = snap[31:24];
      3'd4:    b = snap[23:16];
      3'd5:    b = snap[15:8];
      3'd6:    b = snap[7:0];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  assign w_xfer = r_tx_valid && tx_ready;

  // Frame sequencing: next state, next byte, checksum accumulation and seq advance.
  always_comb begin
    w_state_nx = r_state;
    w_idx_nx   = r_idx;
    w_snap_nx  = r_snap;
    w_csum_nx  = r_csum;
    w_seq_nx   = r_seq;
    w_data_nx  = r_tx_data;
    w_valid_nx = r_tx_valid;
    case (r_state)
      S_IDLE: begin
        if (snap_req) begin
          w_snap_nx  = regs_in;
          w_csum_nx  = r_seq;
          w_state_nx = S_HDR;
          w_valid_nx = 1'b1;
          w_data_nx  = HEADER;
        end else begin
          w_valid_nx = 1'b0;
        end
      end
      S_HDR: begin
        if (w_xfer) begin
          w_state_nx = S_SEQ;
          w_data_nx  = r_seq;
        end else begin
          w_state_nx = S_HDR;
        end
      end
      S_SEQ: begin
        if (w_xfer) begin
          w_state_nx = S_REG;
          w_idx_nx   = 3'd0;
          w_data_nx  = sel_byte(r_snap, 3'd0);
        end else begin
          w_state_nx = S_SEQ;
        end
      end
      S_REG: begin
        if (w_xfer) begin
          // the accumulator absorbs each register byte as it leaves
          w_csum_nx = r_csum ^ r_tx_data;
          if (r_idx == 3'd6) begin
            w_state_nx = S_CSUM;
            w_data_nx  = r_csum ^ r_tx_data;
          end else begin
            w_idx_nx  = r_idx + 3'd1;
            w_data_nx = sel_byte(r_snap, r_idx + 3'd1);
          end
        end else begin
          w_state_nx = S_REG;
        end
      end
      S_CSUM: begin
        if (w_xfer) begin
          w_state_nx = S_IDLE;
          w_valid_nx = 1'b0;
          w_seq_nx   = r_seq + 8'd1;
        end else begin
          w_state_nx = S_CSUM;
        end
      end
      default: begin
        w_state_nx = S_IDLE;
        w_valid_nx = 1'b0;
      end
    endcase
  end

  // Requests arriving outside IDLE are counted, saturating at all-ones.
  always_comb begin
    w_drop_nx = r_drop;
    if (snap_req && (r_state != S_IDLE) && (r_drop != {DROP_W{1'b1}})) begin
      w_drop_nx = r_drop + {{(DROP_W-1){1'b0}}, 1'b1};
    end else begin
      w_drop_nx = r_drop;
    end
  end

  // State and output registers; reset aborts any frame in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_idx      <= 3'd0;
      r_snap     <= 56'd0;
      r_csum     <= 8'h00;
      r_seq      <= 8'h00;
      r_tx_data  <= 8'h00;
      r_tx_valid <= 1'b0;
      r_drop     <= {DROP_W{1'b0}};
    end else begin
      r_state    <= w_state_nx;
      r_idx      <= w_idx_nx;
      r_snap     <= w_snap_nx;
      r_csum     <= w_csum_nx;
      r_seq      <= w_seq_nx;
      r_tx_data  <= w_data_nx;
      r_tx_valid <= w_valid_nx;
      r_drop     <= w_drop_nx;
    end
  end

  assign tx_data  = r_tx_data;
  assign tx_valid = r_tx_valid;
  assign busy     = (r_state != S_IDLE);
  assign seq      = r_seq;
  assign drop_cnt = r_drop;

endmodule
